// File: rtl/flag_set_scheduler_pkg.sv
// Shared types and helpers for the flag set scheduler: FSM state encoding,
// the default key pattern and width helpers for the owner index and counters.
package flag_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DRIVE = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } sched_state_e;

    // Pattern the destination-domain synchroniser recognises as a flag set.
    localparam logic [15:0] KEY_DEFAULT = 16'h12AB;

    // Width of an index over n requesters; never narrower than one bit.
    function automatic int owner_width(input int n);
        return (n < 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    // Width of a counter that must be able to hold the value maxval.
    function automatic int count_width(input int maxval);
        return (maxval < 32'sd1) ? 32'sd1 : $clog2(maxval + 32'sd1);
    endfunction

endpackage

// File: rtl/flag_set_scheduler_rr_arbiter.sv
// Round-robin search: returns the first set request bit at or after the
// pointer, wrapping past the top bit. Purely combinational.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    localparam int SW = IW + 1;

    logic [NREQ-1:0] rot_s;
    logic [IW-1:0]   off_s;
    logic            found_s;
    logic [SW-1:0]   sum_s;

    // Rotate so that the pointer position lands on bit 0.
    assign rot_s = NREQ'({req, req} >> ptr);

    // Lowest set bit of the rotated vector is the distance from the pointer.
    always_comb begin
        off_s   = {IW{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            off_s   = (!found_s && rot_s[k]) ? IW'(k) : off_s;
            found_s = found_s | rot_s[k];
        end
    end

    assign sum_s = {1'b0, ptr} + {1'b0, off_s};
    assign idx   = (sum_s >= SW'(NREQ)) ? IW'(sum_s - SW'(NREQ)) : IW'(sum_s);
    assign valid = found_s;

endmodule

// File: rtl/flag_set_scheduler.sv
// Round-robin owner of one cross-domain flag synchroniser. Each grant pulses
// the flag clear, drives the key pattern for HOLD cycles, waits for the
// returned flag edge, acknowledges the owner and then idles for GAP cycles.
// Optional WAIT timeout is built in when FLAG_SCHED_TIMEOUT_EN is defined.
module flag_set_scheduler #(
    parameter int          NREQ = 4,
    parameter logic [15:0] KEY  = flag_sched_pkg::KEY_DEFAULT,
    parameter int          HOLD = 4,
    parameter int          GAP  = 2,
    parameter int          TMO  = 255,
    localparam int         OW   = flag_sched_pkg::owner_width(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [15:0]     set_pulse,
    output logic            rst_pulse,
    input  logic            flag_seen,
    output logic [OW-1:0]   owner,
    output logic            busy,
    output logic            timeout_err
);

    import flag_sched_pkg::*;

    localparam int CW = count_width((HOLD > GAP) ? HOLD : GAP);

    sched_state_e    state_r;
    logic [OW-1:0]   owner_r;
    logic [OW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r;
    logic            flag_prev_r;
    logic [NREQ-1:0] ack_r;
    logic [15:0]     set_r;
    logic            rst_r;
    logic            busy_r;

    logic [OW-1:0]   grant_idx_s;
    logic            grant_valid_s;
    logic [OW-1:0]   ptr_next_s;
    logic            flag_rise_s;
    logic            wait_expire_s;
    logic [NREQ-1:0] owner_onehot_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_r),
        .idx   (grant_idx_s),
        .valid (grant_valid_s)
    );

    assign ptr_next_s     = (grant_idx_s == OW'(NREQ - 1)) ? {OW{1'b0}} : grant_idx_s + {{(OW-1){1'b0}}, 1'b1};
    // Only a fresh 0->1 transition counts; a level already high is stale.
    assign flag_rise_s    = flag_seen & ~flag_prev_r;
    assign owner_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;

`ifdef FLAG_SCHED_TIMEOUT_EN
    localparam int TW = count_width(TMO);

    logic [TW-1:0] wait_cnt_r;
    logic          tmo_r;

    assign wait_expire_s = (state_r == WAIT) && (wait_cnt_r == TW'(TMO - 1));

    // Cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= {TW{1'b0}};
        end
    end

    // Error pulse only when the budget runs out without a flag edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_r <= 1'b0;
        end else begin
            tmo_r <= wait_expire_s & ~flag_rise_s;
        end
    end

    assign timeout_err = tmo_r;
`else
    // TMO only matters when the timeout is built in.
    logic unused_tmo_s;
    assign unused_tmo_s  = (TMO > 32'sd0);
    assign wait_expire_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Main FSM with registered synchroniser outputs, ack and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= {OW{1'b0}};
            ptr_r       <= {OW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            flag_prev_r <= 1'b0;
            ack_r       <= {NREQ{1'b0}};
            set_r       <= 16'h0000;
            rst_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            flag_prev_r <= flag_seen;
            ack_r       <= {NREQ{1'b0}};
            rst_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    set_r <= 16'h0000;
                    if (grant_valid_s) begin
                        owner_r <= grant_idx_s;
                        ptr_r   <= ptr_next_s;
                        state_r <= CLEAR;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                CLEAR: begin
                    rst_r   <= 1'b1;
                    set_r   <= 16'h0000;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= DRIVE;
                end
                DRIVE: begin
                    if (cnt_r == CW'(HOLD)) begin
                        set_r   <= 16'h0000;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= WAIT;
                    end else begin
                        set_r   <= KEY;
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                WAIT: begin
                    set_r <= 16'h0000;
                    if (flag_rise_s || wait_expire_s) begin
                        ack_r <= owner_onehot_s;
                        cnt_r <= {CW{1'b0}};
                        if (GAP == 32'sd0) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= flag_sched_pkg::GAP;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                flag_sched_pkg::GAP: begin
                    set_r <= 16'h0000;
                    if (cnt_r == CW'(GAP)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    set_r   <= 16'h0000;
                    cnt_r   <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_r;
    assign set_pulse = set_r;
    assign rst_pulse = rst_r;
    assign owner     = owner_r;
    assign busy      = busy_r;

endmodule
